// File: rtl/wb_sdram_traffic_master.sv
// Wishbone traffic initiator for the SDRAM controller app port: pattern writes and read-back
// compare, issued as classic single cycles or as MAX_BL-aligned incrementing bursts.
module wb_sdram_traffic_master #(
  parameter int APP_AW  = 26,
  parameter int dw      = 32,
  parameter int MAX_BL  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              burst_en,
  input  logic [APP_AW-1:0] base_addr,
  input  logic [15:0]       num_words,
  input  logic [dw-1:0]     seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr,
  output logic              timeout_err
);
  localparam int SW = dw / 8;
  localparam int AB = $clog2(SW);
  localparam int LB = $clog2(MAX_BL);
  localparam int BW = LB + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;
  state_t state_q, state_d;

  logic [15:0]       idx_q, idx_d, nw_q, nw_d, err_q, err_d;
  logic [APP_AW-1:0] base_q, base_d, addr_q, addr_d, fea_q, fea_d;
  logic [dw-1:0]     seed_q, seed_d, dat_q, dat_d;
  logic              rd_q, rd_d, wtr_q, wtr_d, burst_q, burst_d;
  logic              cyc_q, cyc_d, we_q, we_d;
  logic [2:0]        cti_q, cti_d;
  logic              busy_q, busy_d, done_q, done_d, tmo_err_q, tmo_err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [BW-1:0]     left_q, left_d;

  // Setup of the first beat of a burst (or of a classic beat); in IDLE it reads the raw inputs
  // so the first beat is on the bus the cycle after start.
  logic [APP_AW-1:0] s_base, s_addr;
  logic [dw-1:0]     s_seed, s_dat;
  logic [15:0]       s_nw, s_idx;
  logic              s_burst;
  logic [16:0]       s_rem;
  logic [LB-1:0]     s_off;
  logic [BW-1:0]     s_room, s_len;
  logic [2:0]        s_cti;

  always_comb begin
    if (state_q == IDLE) begin
      s_base  = {base_addr[APP_AW-1:AB], {AB{1'b0}}};
      s_seed  = seed;
      s_nw    = num_words;
      s_burst = burst_en;
      s_idx   = '0;
    end else begin
      s_base  = base_q;
      s_seed  = seed_q;
      s_nw    = nw_q;
      s_burst = burst_q;
      s_idx   = idx_q;
    end
    s_addr = s_base + (APP_AW'(s_idx) << AB);
    s_dat  = s_seed + dw'(s_idx);
    s_rem  = {1'b0, s_nw} - {1'b0, s_idx};
    s_off  = s_addr[AB +: LB];
    s_room = BW'(MAX_BL) - {1'b0, s_off};
    s_len  = (s_rem < 17'(s_room)) ? s_rem[BW-1:0] : s_room;
    s_cti  = !s_burst ? CTI_CLASSIC : (s_len == BW'(1)) ? CTI_EOB : CTI_INCR;
  end

  logic last_beat;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nw_d      = nw_q;
    err_d     = err_q;
    base_d    = base_q;
    addr_d    = addr_q;
    fea_d     = fea_q;
    seed_d    = seed_q;
    dat_d     = dat_q;
    rd_d      = rd_q;
    wtr_d     = wtr_q;
    burst_d   = burst_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    cti_d     = cti_q;
    busy_d    = busy_q;
    done_d    = done_q;
    tmo_err_d = tmo_err_q;
    tmo_d     = tmo_q;
    left_d    = left_q;
    last_beat = ({1'b0, idx_q} + 17'd1) == {1'b0, nw_q};
    case (state_q)
      IDLE: if (start) begin
        base_d    = s_base;
        seed_d    = seed;
        nw_d      = num_words;
        burst_d   = burst_en;
        rd_d      = mode[0];
        wtr_d     = (mode == 2'b10);
        idx_d     = '0;
        err_d     = '0;
        fea_d     = '0;
        tmo_err_d = 1'b0;
        if (num_words == 16'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = REQ;
          busy_d  = 1'b1;
          cyc_d   = 1'b1;
          we_d    = !mode[0];
          addr_d  = s_addr;
          dat_d   = s_dat;
          cti_d   = s_cti;
          left_d  = s_len;
          tmo_d   = '0;
        end
      end
      REQ: if (wb_ack_i) begin
        tmo_d = '0;
        idx_d = idx_q + 16'd1;
        // dat_q always carries seed+i, so it doubles as the read-back expectation
        if (rd_q && (wb_dat_i != dat_q)) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0)    fea_d = addr_q;
        end
        if (burst_q && (left_q != BW'(1))) begin
          addr_d = addr_q + APP_AW'(SW);
          dat_d  = dat_q + dw'(1);
          left_d = left_q - BW'(1);
          cti_d  = (left_q == BW'(2)) ? CTI_EOB : CTI_INCR;
        end else begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cti_d   = CTI_CLASSIC;
          state_d = GAP;
          if (last_beat) begin
            if (wtr_q && !rd_q) begin
              idx_d = '0;
              rd_d  = 1'b1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end else if (tmo_q == TW'(TIMEOUT)) begin
        cyc_d     = 1'b0;
        we_d      = 1'b0;
        cti_d     = CTI_CLASSIC;
        tmo_err_d = 1'b1;
        state_d   = DONE;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      GAP: begin
        state_d = REQ;
        cyc_d   = 1'b1;
        we_d    = !rd_q;
        addr_d  = s_addr;
        dat_d   = s_dat;
        cti_d   = s_cti;
        left_d  = s_len;
        tmo_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      nw_q      <= '0;
      err_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      fea_q     <= '0;
      seed_q    <= '0;
      dat_q     <= '0;
      rd_q      <= 1'b0;
      wtr_q     <= 1'b0;
      burst_q   <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      cti_q     <= CTI_CLASSIC;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_q     <= '0;
      left_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nw_q      <= nw_d;
      err_q     <= err_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      fea_q     <= fea_d;
      seed_q    <= seed_d;
      dat_q     <= dat_d;
      rd_q      <= rd_d;
      wtr_q     <= wtr_d;
      burst_q   <= burst_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      cti_q     <= cti_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_err_q <= tmo_err_d;
      tmo_q     <= tmo_d;
      left_q    <= left_d;
    end
  end

  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = we_q;
  assign wb_addr_o      = addr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = {SW{cyc_q}};
  assign wb_cti_o       = cti_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_q;
  assign first_err_addr = fea_q;
  assign timeout_err    = tmo_err_q;

endmodule
